// File: rtl/rotary_aim.sv
// -----------------------------------------------------------------------------
// rotary_aim
//
// Aim generator for one player of the SNK68 core. It produces the 12-position
// one-hot rotary word. The position moves in two ways:
//   - manual cw/ccw button edges;
//   - an automatic slew toward the 8-way stick angle, one step every STEP_DIV
//     clk_sys cycles.
//
// Optional feature macro: ROTARY_AIM_AUTO_EN
//   - defined:   stick decode, prescaler and automatic slew are built.
//   - undefined: manual cw/ccw only. The stick inputs are ignored and busy
//                is tied to 0.
//
// Parameters:
//   STEP_DIV  clk_sys cycles between automatic steps (>= 2)
//
// Ports:
//   clk_sys                  in   system clock
//   reset                    in   synchronous, active-high
//   up, down, left, right    in   aim-stick directions, active-high
//   cw, ccw                  in   manual rotate buttons, rising-edge detected
//   rotary[11:0]             out  one-hot aim position (bit pos set)
//   pos[3:0]                 out  position index 0..11
//   busy                     out  automatic slew in progress
// -----------------------------------------------------------------------------
module rotary_aim #(
   parameter int unsigned STEP_DIV = 1200000
) (
   input  logic        clk_sys,
   input  logic        reset,
   input  logic        up,
   input  logic        down,
   input  logic        left,
   input  logic        right,
   input  logic        cw,
   input  logic        ccw,
   output logic [11:0] rotary,
   output logic [3:0]  pos,
   output logic        busy
);

   logic        cw_p0;
   logic        ccw_p0;
   logic        cw_p1;
   logic        ccw_p1;
   logic        cw_rise;
   logic        ccw_rise;
   logic        man_cw;
   logic        man_ccw;
   logic        man_step;
   logic        busy_c;
   logic        auto_due;
   logic        auto_ccw;
   logic [3:0]  pos_q;
   logic [3:0]  pos_nxt;
   logic [11:0] rotary_q;

   // Position arithmetic, wrapping modulo 12.
   function automatic logic [3:0] pos_inc(input logic [3:0] p);
      return (p == 4'd11) ? 4'd0 : p + 4'd1;
   endfunction

   function automatic logic [3:0] pos_dec(input logic [3:0] p);
      return (p == 4'd0) ? 4'd11 : p - 4'd1;
   endfunction

   // (t - p) mod 12, formed as a signed difference folded into 0..11.
   function automatic logic [3:0] dist12(input logic [3:0] t, input logic [3:0] p);
      logic signed [4:0] diff;
      diff = signed'({1'b0, t}) - signed'({1'b0, p});
      if (diff < 5'sd0) diff = diff + 5'sd12;
      return diff[3:0];
   endfunction

   // ---- stage p0 / p1: button registration and edge history ----
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         cw_p0  <= 1'b0;
         ccw_p0 <= 1'b0;
         cw_p1  <= 1'b0;
         ccw_p1 <= 1'b0;
      end else begin
         cw_p0  <= cw;
         ccw_p0 <= ccw;
         cw_p1  <= cw_p0;
         ccw_p1 <= ccw_p0;
      end
   end

   assign cw_rise  = cw_p0 & ~cw_p1;
   assign ccw_rise = ccw_p0 & ~ccw_p1;
   // Simultaneous edges in both directions cancel each other.
   assign man_cw   = cw_rise & ~ccw_rise;
   assign man_ccw  = ccw_rise & ~cw_rise;
   assign man_step = man_cw | man_ccw;

`ifdef ROTARY_AIM_AUTO_EN
   localparam int CNT_W = $clog2(STEP_DIV);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEP_DIV - 1);

   logic             up_p0;
   logic             down_p0;
   logic             left_p0;
   logic             right_p0;
   logic [3:0]       tgt;
   logic             tvalid;
   logic [3:0]       dist;
   logic [CNT_W-1:0] cnt;

   // ---- stage p0: stick registration ----
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         up_p0    <= 1'b0;
         down_p0  <= 1'b0;
         left_p0  <= 1'b0;
         right_p0 <= 1'b0;
      end else begin
         up_p0    <= up;
         down_p0  <= down;
         left_p0  <= left;
         right_p0 <= right;
      end
   end

   // Opposing directions pressed together give no usable angle.
   always_comb begin
      tgt    = 4'd0;
      tvalid = (up_p0 | down_p0 | left_p0 | right_p0)
               & ~(up_p0 & down_p0) & ~(left_p0 & right_p0);
      if (up_p0) begin
         if (left_p0)       tgt = 4'd2;
         else if (right_p0) tgt = 4'd10;
         else               tgt = 4'd0;
      end else if (down_p0) begin
         if (left_p0)       tgt = 4'd5;
         else if (right_p0) tgt = 4'd7;
         else               tgt = 4'd6;
      end else if (left_p0) begin
         tgt = 4'd3;
      end else begin
         tgt = 4'd9;
      end
   end

   assign dist     = dist12(tgt, pos_q);
   assign busy_c   = tvalid & (dist != 4'd0);
   // A half-turn (dist 6) resolves counter-clockwise.
   assign auto_ccw = (dist <= 4'd6);
   assign auto_due = busy_c & (cnt == CNT_LAST);

   // The prescaler only runs while a slew is pending. Any manual step
   // restarts the interval.
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         cnt <= '0;
      end else if (man_step || !busy_c || cnt == CNT_LAST) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + CNT_W'(1);
      end
   end
`else
   logic unused_stick;
   assign unused_stick = ^{up, down, left, right};
   assign busy_c       = 1'b0;
   assign auto_due     = 1'b0;
   assign auto_ccw     = 1'b0;
`endif

   // A manual edge takes priority; a coincident auto step is dropped.
   always_comb begin
      pos_nxt = pos_q;
      if (man_cw)        pos_nxt = pos_dec(pos_q);
      else if (man_ccw)  pos_nxt = pos_inc(pos_q);
      else if (auto_due) pos_nxt = auto_ccw ? pos_inc(pos_q) : pos_dec(pos_q);
   end

   // ---- output register: position and its one-hot image ----
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         pos_q    <= 4'd0;
         rotary_q <= 12'h001;
      end else begin
         pos_q    <= pos_nxt;
         rotary_q <= 12'd1 << pos_nxt;
      end
   end

   assign rotary = rotary_q;
   assign pos    = pos_q;
   assign busy   = busy_c;

endmodule
